alu_wide_seq: RTL and testbench
===============================

Name: alu_wide_seq

Overview:
- Operation sequencer that drives the registered 8-bit ALU (ops ADD/AND/OR/XOR, one-cycle latency) to perform N_BYTES-wide operations.
- Accepts a wide request over a valid/ready handshake and issues one byte-pass at a time to the ALU, least significant byte first.
- Chains carries through extra "+1" fix passes, because the ALU has no carry-in.
- Returns the wide result and aggregated flags to the requester (datapath controller) over a valid/ready handshake.

Parameters:
- N_BYTES, 2, operand/result width in bytes (W = 8*N_BYTES); legal values 1..4.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous active-low reset
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid & o_ready at posedge
- i_op  in  3  0 ADD, 1 AND, 2 OR, 3 XOR, 4 SUB (macro only), others illegal
- i_a  in  W  left operand
- i_b  in  W  right operand
- o_valid  out  1  result valid; held until taken
- i_ready  in  1  result taken when o_valid & i_ready at posedge
- o_result  out  W  wide result
- o_flags  out  4  {E illegal-op, N = result[W-1], C carry-out, Z = result==0}
- o_alu_l  out  8  ALU left operand
- o_alu_r  out  8  ALU right operand
- o_alu_op  out  3  ALU op
- i_alu  in  8  ALU result; reflects inputs of the previous cycle
- i_alu_flags  in  4  ALU flags; only bit1 (C) used; Z and N are recomputed here

Behaviour:
- Clock and reset: one clock i_clk; reset synchronous, active-low on i_reset_n.
- Reset values: state IDLE; o_ready=1; o_valid=0; o_result=0; o_flags=0; ALU outputs 0 with op ADD.
- Reset mid-operation: aborts immediately and returns to IDLE next edge. Captured bytes are discarded.
- States and transitions:
  - IDLE (o_ready=1): on accept, latch i_a, i_b, i_op.
    - Legal op: go to ISSUE with byte k=0 and cin = (op==SUB).
    - Illegal op: go to DONE with result 0, flags 4'b1000.
  - ISSUE, main pass: drive o_alu_l=a[k], o_alu_r = (SUB ? ~b[k] : b[k]), o_alu_op = (SUB ? ADD : op). Go to CAPTURE.
  - CAPTURE, main pass: res[k]=i_alu; cm=i_alu_flags[1].
    - ADD/SUB with cin=1: go to FIX.
    - Otherwise: cout=cm and advance.
  - FIX: drive res[k], 8'h01, ADD. Go to FIXCAP.
  - FIXCAP: res[k]=i_alu; cout = cm | i_alu_flags[1]; advance.
  - Advance: cin=cout; k+1. Go to ISSUE if k<N_BYTES-1, else DONE.
  - DONE: o_valid=1 with result and flags stable. Leave for IDLE when i_ready is sampled high. o_ready=0 outside IDLE.
- Flags:
  - C = cout of the top byte for ADD/SUB; C = 0 for logic ops. For SUB, C=1 means no borrow (a >= b).
  - Z and N are taken from the full W-bit result. E=0 for legal ops.
- ALU idle drive: in non-ISSUE/FIX states, ALU outputs are 0 with op ADD. The ALU's result is only sampled in CAPTURE/FIXCAP.
- Latency: P = number of passes (N_BYTES main passes plus one per fix). Each pass takes 2 cycles. o_valid rises 2P+1 cycles after the accept edge.
  - N_BYTES=2 logic op: valid at cycle 5.
  - Illegal op: valid at cycle 1.
- Throughput: one request in flight; no new accept until DONE is released.
- Boundary: carry from a fix pass cannot coincide with a main-pass carry within the same byte, so OR-combining the two is exact.

Optional Feature:
- ALU_WIDE_SUB_EN.
- Defined: op 4 = SUB, computed as a + ~b + 1 with cin0=1 forced, so byte 0 always takes a fix pass.
- Undefined: op 4 is illegal (E=1, result 0, flags 4'b1000, one-cycle turnaround).

Decomposition:
- Shared package alu_pkg:
  - op codes OP_ADD..OP_SUB
  - flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_E=3
  - state enum
- No sub-module: a single FSM plus a byte-indexed result register. The existing 8-bit ALU is instantiated alongside this block in the bench and at the top level.

Test Plan:
- ADD 0x00FF + 0x0001 → passes lo, lo-fix skipped, hi, hi-fix (cin=1). Result 0x0100, flags 4'b0000, valid at cycle 7.
- ADD 0xFFFF + 0x0001 → result 0x0000, flags C=1, Z=1 (4'b0011).
- XOR 0xA5A5 ^ 0xA5A5 → result 0x0000, flags 4'b0001, valid at cycle 5. AND 0x8F0F & 0xF0FF → 0x800F, N=1 (4'b0100).
- SUB (macro on) 0x0000 - 0x0000 → result 0x0000, flags 4'b0011. 0x0003 - 0x0005 → 0xFFFE, flags 4'b0100 (C=0, borrow).
- Illegal op 7, and op 4 with macro off → result 0, flags 4'b1000 at cycle 1. Hold i_ready=0 for 3 cycles → o_valid and outputs stable; o_ready stays 0.
- Reset pulsed low during the hi ISSUE state → next cycle IDLE, o_ready=1, o_valid=0. A subsequent ADD 0x1234 + 0x1111 → 0x2345.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the wide ALU sequencer.
// Op codes, flag bit positions and the sequencer state enum.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_E = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_FIX,
    S_FIXCAP,
    S_DONE
  } state_e;

endpackage

// File: rtl/alu_wide_seq.sv
// Sequences the registered 8-bit ALU to perform N_BYTES-wide ops,
// LSB first, chaining carries through "+1" fix passes.
// Ports: i_clk, i_reset_n (sync, active-low);
//   request  i_valid/o_ready, i_op, i_a, i_b;
//   response o_valid/i_ready, o_result, o_flags {E,N,C,Z};
//   ALU side o_alu_l, o_alu_r, o_alu_op, i_alu, i_alu_flags.
// Macro ALU_WIDE_SUB_EN enables op 4 = SUB; otherwise op 4 is illegal.
module alu_wide_seq
  import alu_pkg::*;
#(
  parameter int N_BYTES = 2,
  localparam int W = 8 * N_BYTES
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [2:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_result,
  output logic [3:0]   o_flags,
  output logic [7:0]   o_alu_l,
  output logic [7:0]   o_alu_r,
  output logic [2:0]   o_alu_op,
  input  logic [7:0]   i_alu,
  input  logic [3:0]   i_alu_flags
);

  localparam int KW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  typedef logic [N_BYTES-1:0][7:0] bytes_t;

  state_e state_q, state_d;
  bytes_t a_q, a_d;
  bytes_t b_q, b_d;
  bytes_t res_q, res_d;
  logic [2:0] op_q, op_d;
  logic [KW-1:0] k_q, k_d;
  logic cin_q, cin_d;
  logic cm_q, cm_d;
  logic [3:0] flags_q, flags_d;

  logic sub;
  logic arith;
  logic legal_in;
  logic adv;
  logic carry;
  logic last;

  logic unused_flags;
  assign unused_flags = ^{i_alu_flags[3:2], i_alu_flags[0]};

`ifdef ALU_WIDE_SUB_EN
  assign sub      = (op_q == OP_SUB);
  assign legal_in = (i_op <= OP_SUB);
`else
  assign sub      = 1'b0;
  assign legal_in = (i_op <= OP_XOR);
`endif

  assign arith = (op_q == OP_ADD) | sub;
  assign last  = (k_q == KW'(N_BYTES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= OP_ADD;
      k_q     <= '0;
      cin_q   <= 1'b0;
      cm_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      k_q     <= k_d;
      cin_q   <= cin_d;
      cm_q    <= cm_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    op_d     = op_q;
    k_d      = k_q;
    cin_d    = cin_q;
    cm_d     = cm_q;
    flags_d  = flags_q;
    o_alu_l  = 8'h00;
    o_alu_r  = 8'h00;
    o_alu_op = OP_ADD;
    adv      = 1'b0;
    carry    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d   = i_a;
          b_d   = i_b;
          op_d  = i_op;
          k_d   = '0;
          res_d = '0;
          if (legal_in) begin
            cin_d   = (i_op == OP_SUB);
            flags_d = '0;
            state_d = S_ISSUE;
          end else begin
            flags_d = 4'b1000;
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        o_alu_l  = a_q[k_q];
        o_alu_r  = sub ? ~b_q[k_q] : b_q[k_q];
        o_alu_op = sub ? OP_ADD : op_q;
        state_d  = S_CAPTURE;
      end
      S_CAPTURE: begin
        res_d[k_q] = i_alu;
        cm_d       = i_alu_flags[FLAG_C];
        if (arith && cin_q) begin
          state_d = S_FIX;
        end else begin
          carry = i_alu_flags[FLAG_C];
          adv   = 1'b1;
        end
      end
      S_FIX: begin
        o_alu_l = res_q[k_q];
        o_alu_r = 8'h01;
        state_d = S_FIXCAP;
      end
      S_FIXCAP: begin
        res_d[k_q] = i_alu;
        // A byte that carried in the main pass is <= 0xFE,
        // so the +1 fix cannot carry again: OR is exact.
        carry = cm_q | i_alu_flags[FLAG_C];
        adv   = 1'b1;
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      cin_d = carry;
      if (last) begin
        state_d         = S_DONE;
        flags_d[FLAG_E] = 1'b0;
        flags_d[FLAG_N] = res_d[N_BYTES-1][7];
        flags_d[FLAG_C] = arith & carry;
        flags_d[FLAG_Z] = (res_d == '0);
      end else begin
        k_d     = k_q + KW'(1);
        state_d = S_ISSUE;
      end
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = res_q;
  assign o_flags  = flags_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq with a behavioural 8-bit ALU alongside.
// Checks against a wide-arithmetic reference model plus literals.
module tb_alu_wide_seq;

  localparam int N = 2;
  localparam int W = 8 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [2:0]   i_op;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_result;
  logic [3:0]   o_flags;
  logic [7:0]   alu_l;
  logic [7:0]   alu_r;
  logic [2:0]   alu_op;
  logic [7:0]   alu_y = 8'h00;
  logic [3:0]   alu_f = 4'h0;

  int checks = 0;
  int errors = 0;

  logic         active = 1'b0;
  int           cyc = 0;
  logic [W-1:0] exp_res;
  logic [3:0]   exp_flags;
  int           exp_lat;

  always #5 clk = ~clk;

  alu_wide_seq #(.N_BYTES(N)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_op        (i_op),
    .i_a         (i_a),
    .i_b         (i_b),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_flags     (o_flags),
    .o_alu_l     (alu_l),
    .o_alu_r     (alu_r),
    .o_alu_op    (alu_op),
    .i_alu       (alu_y),
    .i_alu_flags (alu_f)
  );

  // Registered 8-bit ALU: flags {0, N, C, Z}.
  always @(posedge clk) begin
    logic [8:0] s;
    s = 9'h000;
    case (alu_op)
      3'd0: s = {1'b0, alu_l} + {1'b0, alu_r};
      3'd1: s = {1'b0, alu_l & alu_r};
      3'd2: s = {1'b0, alu_l | alu_r};
      3'd3: s = {1'b0, alu_l ^ alu_r};
      default: s = 9'h000;
    endcase
    alu_y <= s[7:0];
    alu_f <= {1'b0, s[7], s[8], s[7:0] == 8'h00};
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic; one extra pass for every
  // byte that receives a carry-in.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    logic legal, is_sub, ar;
    logic [W-1:0] bb;
    logic [W:0] full;
    longint lo_a, lo_b, m;
    int passes;
`ifdef ALU_WIDE_SUB_EN
    legal = (op <= 3'd4);
`else
    legal = (op <= 3'd3);
`endif
    if (!legal) begin
      exp_res = '0;
      exp_flags = 4'b1000;
      exp_lat = 1;
      return;
    end
    is_sub = (op == 3'd4);
    ar = (op == 3'd0) || is_sub;
    bb = is_sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (W+1)'(is_sub);
    case (op)
      3'd1: exp_res = a & b;
      3'd2: exp_res = a | b;
      3'd3: exp_res = a ^ b;
      default: exp_res = full[W-1:0];
    endcase
    passes = N;
    if (ar) begin
      for (int k = 0; k < N; k++) begin
        m = longint'(1) << (8 * k);
        lo_a = longint'(a) % m;
        lo_b = longint'(bb) % m;
        if ((lo_a + lo_b + longint'(is_sub)) >= m) passes++;
      end
    end
    exp_lat = 2 * passes + 1;
    exp_flags = {1'b0, exp_res[W-1], ar & full[W], exp_res == '0};
  endtask

  // Per-cycle compare while a request is in flight.
  always @(negedge clk) begin
    if (active) begin
      cyc = cyc + 1;
      chk("valid", 32'(o_valid), 32'(cyc >= exp_lat));
      chk("ready_busy", 32'(o_ready), 32'd0);
      if (cyc >= exp_lat) begin
        chk("result", 32'(o_result), 32'(exp_res));
        chk("flags", 32'(o_flags), 32'(exp_flags));
      end
    end else begin
      cyc = 0;
    end
  end

  task automatic run(input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int hold,
                     input logic [W-1:0] lr, input logic [3:0] lf,
                     input int ll);
    int n;
    @(negedge clk);
    chk("ready_idle", 32'(o_ready), 32'd1);
    i_op = op;
    i_a = a;
    i_b = b;
    i_valid = 1'b1;
    i_ready = (hold == 0);
    model(op, a, b);
    @(posedge clk);
    active = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      i_valid = 1'b0;
      n++;
      if (o_valid) break;
    end
    if (!o_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout op=%0d actual=no_valid required=valid", op);
      active = 1'b0;
      return;
    end
    chk("lit_lat", 32'(n), 32'(ll));
    chk("lit_res", 32'(o_result), 32'(lr));
    chk("lit_flags", 32'(o_flags), 32'(lf));
    repeat (hold) @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    active = 1'b0;
    @(negedge clk);
    chk("released_valid", 32'(o_valid), 32'd0);
    chk("released_ready", 32'(o_ready), 32'd1);
    i_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_op = 3'd0;
    i_a = '0;
    i_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_result", 32'(o_result), 32'd0);
    chk("rst_flags", 32'(o_flags), 32'd0);
    chk("rst_alu", {13'd0, alu_op, alu_l, alu_r}, 32'd0);
    rst_n = 1'b1;

    run(3'd0, 16'h00FF, 16'h0001, 0, 16'h0100, 4'b0000, 7);
    run(3'd0, 16'hFFFF, 16'h0001, 0, 16'h0000, 4'b0011, 7);
    run(3'd0, 16'h80FF, 16'h8001, 0, 16'h0100, 4'b0010, 7);
    run(3'd3, 16'hA5A5, 16'hA5A5, 0, 16'h0000, 4'b0001, 5);
    run(3'd1, 16'h8F0F, 16'hF0FF, 0, 16'h800F, 4'b0100, 5);
    run(3'd2, 16'h1200, 16'h0034, 1, 16'h1234, 4'b0000, 5);
    run(3'd7, 16'h1234, 16'h5678, 3, 16'h0000, 4'b1000, 1);
`ifdef ALU_WIDE_SUB_EN
    run(3'd4, 16'h0000, 16'h0000, 0, 16'h0000, 4'b0011, 9);
    run(3'd4, 16'h0003, 16'h0005, 0, 16'hFFFE, 4'b0100, 7);
`else
    run(3'd4, 16'h0003, 16'h0005, 2, 16'h0000, 4'b1000, 1);
`endif

    // Abort during the high-byte ISSUE.
    @(negedge clk);
    i_op = 3'd0;
    i_a = 16'h12FF;
    i_b = 16'h3401;
    i_valid = 1'b1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      i_valid = 1'b0;
    end
    chk("hi_issue_l", 32'(alu_l), 32'h12);
    chk("hi_issue_r", 32'(alu_r), 32'h34);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ready", 32'(o_ready), 32'd1);
    chk("abort_valid", 32'(o_valid), 32'd0);
    chk("abort_result", 32'(o_result), 32'd0);
    rst_n = 1'b1;

    run(3'd0, 16'h1234, 16'h1111, 0, 16'h2345, 4'b0000, 5);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
